// File: rtl/approval_preloader.sv
// Streams matching, checksum-valid governance approval records from FRAM into
// the governance threshold checker's preload port, counting accepts and skips.
module approval_preloader #(
    parameter int          N_RECORDS    = 16,
    parameter logic [15:0] BASE_ADDR    = 16'h0100,
    parameter int          WORD_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_start,
    input  logic         abort,
    input  logic [5:0]   req_bitstream_id,
    input  logic [31:0]  req_target_version,
    output logic         mem_req,
    output logic [15:0]  mem_addr,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    output logic         preload_valid,
    output logic [7:0]   preload_signer_id,
    output logic [127:0] preload_hash,
    output logic [31:0]  preload_expiry,
    output logic         busy,
    output logic         load_done,
    output logic [7:0]   records_accepted,
    output logic [7:0]   records_skipped,
    output logic         mem_timeout,
    output logic         aborted
);

    typedef enum logic [2:0] {IDLE, REQ, GAP, CHECK, EMIT, DONE} state_t;

    localparam logic [7:0]  LAST_IDX = 8'(N_RECORDS - 1);
    localparam logic [31:0] TMO_LAST = 32'(WORD_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [7:0]    rec_idx;
    logic [2:0]    word_idx;
    logic [31:0]   tmo_cnt;
    logic          skip_rec;
    logic [31:0]   version_q;
    logic [31:0]   csum_q;

    logic take, hdr_end, hdr_bad, tmo_hit, last_rec, rec_ok;

    always_comb begin
        take     = (state == REQ) && mem_rvalid && !abort;
        hdr_end  = (word_idx == 3'd0) && (mem_rdata[31:24] == 8'hFF);
        hdr_bad  = (word_idx == 3'd0) && !hdr_end &&
                   ((mem_rdata[31:24] != 8'hA5) || (mem_rdata[13:8] != req_bitstream_id));
        tmo_hit  = (state == REQ) && !mem_rvalid && !abort && (tmo_cnt == TMO_LAST);
        last_rec = (rec_idx == LAST_IDX);
        // csum_q folds in w7 as well, so a consistent record leaves zero
        rec_ok   = (version_q == req_target_version) && (csum_q == 32'h0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        mem_req       = (state == REQ);
        mem_addr      = '0;
        preload_valid = (state == EMIT) && !abort;
        busy          = (state == REQ) || (state == GAP) || (state == CHECK) || (state == EMIT);
        load_done     = (state == DONE);
        if (state == REQ)
            mem_addr = BASE_ADDR + {5'b0, rec_idx, 3'b0} + {13'b0, word_idx};
        case (state)
            IDLE:  if (load_start) state_nxt = REQ;
            REQ: begin
                if (abort)                  state_nxt = DONE;
                else if (mem_rvalid) begin
                    if (hdr_end)            state_nxt = DONE;
                    else if (word_idx == 3'd7) state_nxt = CHECK;
                    else                    state_nxt = GAP;
                end
                else if (tmo_hit)           state_nxt = DONE;
            end
            GAP: begin
                if (abort)                  state_nxt = DONE;
                else if (skip_rec && last_rec) state_nxt = DONE;
                else                        state_nxt = REQ;
            end
            CHECK: begin
                if (abort)                  state_nxt = DONE;
                else if (rec_ok)            state_nxt = EMIT;
                else if (last_rec)          state_nxt = DONE;
                else                        state_nxt = REQ;
            end
            EMIT: begin
                if (abort || last_rec)      state_nxt = DONE;
                else                        state_nxt = REQ;
            end
            DONE:                           state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_idx           <= '0;
            word_idx          <= '0;
            tmo_cnt           <= '0;
            skip_rec          <= 1'b0;
            version_q         <= '0;
            csum_q            <= '0;
            preload_signer_id <= '0;
            preload_hash      <= '0;
            preload_expiry    <= '0;
            records_accepted  <= '0;
            records_skipped   <= '0;
            mem_timeout       <= 1'b0;
            aborted           <= 1'b0;
        end else begin
            if (abort && busy) aborted <= 1'b1;
            case (state)
                IDLE: if (load_start) begin
                    rec_idx          <= '0;
                    word_idx         <= '0;
                    tmo_cnt          <= '0;
                    skip_rec         <= 1'b0;
                    records_accepted <= '0;
                    records_skipped  <= '0;
                    mem_timeout      <= 1'b0;
                    aborted          <= 1'b0;
                end
                REQ: begin
                    if (take) begin
                        word_idx <= word_idx + 3'd1;
                        tmo_cnt  <= '0;
                        csum_q   <= (word_idx == 3'd0) ? mem_rdata : (csum_q ^ mem_rdata);
                        case (word_idx)
                            3'd0: preload_signer_id     <= mem_rdata[23:16];
                            3'd1: version_q             <= mem_rdata;
                            3'd2: preload_expiry        <= mem_rdata;
                            3'd3: preload_hash[127:96]  <= mem_rdata;
                            3'd4: preload_hash[95:64]   <= mem_rdata;
                            3'd5: preload_hash[63:32]   <= mem_rdata;
                            3'd6: preload_hash[31:0]    <= mem_rdata;
                            default: ;
                        endcase
                        if (hdr_bad) begin
                            skip_rec        <= 1'b1;
                            records_skipped <= records_skipped + 8'd1;
                        end
                    end else if (!abort) begin
                        if (tmo_hit) mem_timeout <= 1'b1;
                        else         tmo_cnt     <= tmo_cnt + 32'd1;
                    end
                end
                GAP: if (!abort && skip_rec) begin
                    skip_rec <= 1'b0;
                    word_idx <= '0;
                    rec_idx  <= rec_idx + 8'd1;
                end
                CHECK: if (!abort && !rec_ok) begin
                    records_skipped <= records_skipped + 8'd1;
                    rec_idx         <= rec_idx + 8'd1;
                end
                EMIT: if (!abort) begin
                    records_accepted <= records_accepted + 8'd1;
                    rec_idx          <= rec_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approval_preloader.sv
// Randomized scoreboard bench for approval_preloader: a table-level reference
// model predicts each preload strobe (fields and cycle) and the scan totals.
module tb_approval_preloader;

    typedef struct {
        logic [7:0]   signer;
        logic [127:0] hash;
        logic [31:0]  expiry;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, load_start, abort, load_start2;
    logic [5:0]   req_id;
    logic [31:0]  req_ver;
    logic         mem_req, mem_rvalid, preload_valid, busy, load_done;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_rdata, preload_expiry;
    logic [7:0]   preload_signer_id, records_accepted, records_skipped;
    logic [127:0] preload_hash;
    logic         mem_timeout, aborted;

    logic         mem_req2, mem_rvalid2, preload_valid2, busy2, load_done2, mem_timeout2, aborted2;
    logic [15:0]  mem_addr2;
    logic [31:0]  mem_rdata2, preload_expiry2;
    logic [7:0]   preload_signer_id2, records_accepted2, records_skipped2;
    logic [127:0] preload_hash2;

    logic [31:0]  mem [0:65535];
    int           waits = 0;
    int           hang_from = -1;
    int           wcnt = 0;
    int unsigned  cyc = 0;
    int unsigned  t0 = 0;
    logic         clr_stats = 1'b0;
    logic [15:0]  max_addr = '0;
    int           n2 = 0;
    logic [15:0]  addr8 = 16'hAAAA;
    logic [15:0]  rel_addr;
    logic         hang;

    int checks = 0;
    int errors = 0;
    int exp_acc, exp_skip, exp_done;
    exp_t sb[$];

    approval_preloader #(.N_RECORDS(16), .BASE_ADDR(16'h0100), .WORD_TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .abort(abort),
        .req_bitstream_id(req_id), .req_target_version(req_ver),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .preload_valid(preload_valid), .preload_signer_id(preload_signer_id),
        .preload_hash(preload_hash), .preload_expiry(preload_expiry),
        .busy(busy), .load_done(load_done),
        .records_accepted(records_accepted), .records_skipped(records_skipped),
        .mem_timeout(mem_timeout), .aborted(aborted)
    );

    approval_preloader #(.N_RECORDS(2), .BASE_ADDR(16'hFFF8), .WORD_TIMEOUT(1024)) dut_wrap (
        .clk(clk), .rst(rst), .load_start(load_start2), .abort(1'b0),
        .req_bitstream_id(req_id), .req_target_version(req_ver),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2),
        .preload_valid(preload_valid2), .preload_signer_id(preload_signer_id2),
        .preload_hash(preload_hash2), .preload_expiry(preload_expiry2),
        .busy(busy2), .load_done(load_done2),
        .records_accepted(records_accepted2), .records_skipped(records_skipped2),
        .mem_timeout(mem_timeout2), .aborted(aborted2)
    );

    // Memory model: fixed wait states per word, optional black hole past an offset
    always_comb begin
        rel_addr    = mem_addr - 16'h0100;
        hang        = (hang_from >= 0) && ({16'b0, rel_addr} >= 32'(hang_from));
        mem_rvalid  = mem_req && (wcnt == waits) && !hang;
        mem_rdata   = mem[mem_addr];
        mem_rvalid2 = mem_req2;
        mem_rdata2  = mem[mem_addr2];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_req || mem_rvalid) wcnt <= 0;
        else                        wcnt <= wcnt + 1;
        if (clr_stats) begin
            max_addr <= '0;
            n2       <= 0;
            addr8    <= 16'hAAAA;
        end else begin
            if (mem_req && mem_rvalid && mem_addr > max_addr) max_addr <= mem_addr;
            if (mem_req2) begin
                if (n2 == 8) addr8 <= mem_addr2;
                n2 <= n2 + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (preload_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_preload", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("preload_cycle", 128'(cyc - t0), 128'(e.cyc));
                chk("preload_signer", preload_signer_id, e.signer);
                chk("preload_hash", preload_hash, e.hash);
                chk("preload_expiry", preload_expiry, e.expiry);
            end
        end
    end

    function automatic logic [15:0] waddr(input logic [15:0] base, input int i, input int k);
        return base + 16'(8 * i + k);
    endfunction

    task automatic put_rec(input logic [15:0] base, input int i, input logic [7:0] magic,
                           input logic [5:0] id, input logic [31:0] ver, input logic [31:0] flip);
        logic [31:0] w [8];
        logic [31:0] r, x;
        r = $urandom();
        w[0] = {magic, r[23:14], id, r[7:0]};
        w[1] = ver;
        for (int k = 2; k < 7; k++) w[k] = $urandom();
        x = '0;
        for (int k = 0; k < 7; k++) x ^= w[k];
        w[7] = x ^ flip;
        for (int k = 0; k < 8; k++) mem[waddr(base, i, k)] = w[k];
    endtask

    // Table-level prediction: walk the records, apply the filter rules, accumulate cycle costs
    task automatic model_scan(input logic [15:0] base, input int n, input int w,
                              input logic [5:0] id, input logic [31:0] ver);
        int c;
        logic [31:0] h, x;
        exp_t e;
        c = 1; exp_acc = 0; exp_skip = 0;
        for (int i = 0; i < n; i++) begin
            h = mem[waddr(base, i, 0)];
            if (h[31:24] == 8'hFF) begin
                exp_done = c + 1 + w;
                return;
            end
            if (h[31:24] != 8'hA5 || h[13:8] != id) begin
                exp_skip++;
                c += 2 + w;
                continue;
            end
            x = '0;
            for (int k = 0; k < 7; k++) x ^= mem[waddr(base, i, k)];
            if (mem[waddr(base, i, 1)] == ver && x == mem[waddr(base, i, 7)]) begin
                e.signer = h[23:16];
                e.hash   = {mem[waddr(base, i, 3)], mem[waddr(base, i, 4)],
                            mem[waddr(base, i, 5)], mem[waddr(base, i, 6)]};
                e.expiry = mem[waddr(base, i, 2)];
                e.cyc    = c + 16 + 8 * w;
                sb.push_back(e);
                exp_acc++;
                c += 17 + 8 * w;
            end else begin
                exp_skip++;
                c += 16 + 8 * w;
            end
        end
        exp_done = c;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
    endtask

    task automatic start();
        @(posedge clk); #1;
        load_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int rel);
        rel = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (load_done) begin
                rel = int'(cyc - t0);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_preload_valid"}, preload_valid, 0);
        chk({tag, "_hash"}, preload_hash, 0);
        chk({tag, "_signer_expiry"}, {preload_signer_id, preload_expiry}, 0);
        chk({tag, "_busy_done"}, {busy, load_done}, 0);
        chk({tag, "_counters"}, {records_accepted, records_skipped}, 0);
        chk({tag, "_flags"}, {mem_timeout, aborted}, 0);
        chk({tag, "_wrap_outputs"}, {mem_req2, mem_addr2, busy2, records_accepted2}, 0);
    endtask

    task automatic run_scan(input string tag, input int n, input int w, input int extra);
        int rel;
        waits = w;
        pulse_clr();
        model_scan(16'h0100, n, w, req_id, req_ver);
        start();
        if (extra > 0) begin
            repeat (extra - 1) @(posedge clk);
            #1 load_start = 1'b1;
            @(posedge clk); #1 load_start = 1'b0;
        end
        wait_done(3000, rel);
        chk({tag, "_done_cycle"}, 128'(rel), 128'(exp_done));
        chk({tag, "_accepted"}, records_accepted, 8'(exp_acc));
        chk({tag, "_skipped"}, records_skipped, 8'(exp_skip));
        chk({tag, "_flags"}, {mem_timeout, aborted, busy}, 0);
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    task automatic fill_valid(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) put_rec(base, i, 8'hA5, req_id, req_ver, 0);
    endtask

    initial begin
        int rel, t, ff_at;
        logic [5:0] bad_id;
        rst = 1'b1; load_start = 1'b0; load_start2 = 1'b0; abort = 1'b0;
        req_id = 6'($urandom()); req_ver = $urandom();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        fill_valid(16'h0100, 16);
        run_scan("full", 16, 0, 0);

        put_rec(16'h0100, 2, 8'h00, req_id, req_ver, 0);
        put_rec(16'h0100, 3, 8'hA5, req_id, req_ver ^ 32'h1, 0);
        put_rec(16'h0100, 4, 8'hA5, req_id, req_ver, 32'h1);
        put_rec(16'h0100, 5, 8'hFF, req_id, req_ver, 0);
        run_scan("mixed", 16, 0, 0);
        chk("mixed_max_addr", max_addr, 16'h0100 + 16'd40);

        for (int it = 0; it < 4; it++) begin
            ff_at = (it == 3) ? int'($urandom_range(4, 15)) : 99;
            for (int i = 0; i < 16; i++) begin
                t = $urandom_range(0, 7);
                bad_id = req_id ^ 6'($urandom_range(1, 63));
                if (i == ff_at)  put_rec(16'h0100, i, 8'hFF, req_id, req_ver, 0);
                else if (t == 4) put_rec(16'h0100, i, 8'h5A ^ 8'($urandom_range(1, 3)), req_id, req_ver, 0);
                else if (t == 5) put_rec(16'h0100, i, 8'hA5, bad_id, req_ver, 0);
                else if (t == 6) put_rec(16'h0100, i, 8'hA5, req_id, req_ver ^ ($urandom() | 32'h1), 0);
                else if (t == 7) put_rec(16'h0100, i, 8'hA5, req_id, req_ver, 32'(1) << $urandom_range(0, 31));
                else             put_rec(16'h0100, i, 8'hA5, req_id, req_ver, 0);
            end
            run_scan("random", 16, $urandom_range(0, 2), 0);
        end

        fill_valid(16'h0100, 16);
        waits = 3; hang_from = 13;
        pulse_clr();
        model_scan(16'h0100, 1, 3, req_id, req_ver);
        exp_done = exp_done + 5 * (1 + 3) + 5 + 1024;
        start();
        wait_done(3000, rel);
        chk("timeout_done_cycle", 128'(rel), 128'(exp_done));
        chk("timeout_flag", {mem_timeout, aborted}, 2'b10);
        chk("timeout_accepted", records_accepted, 1);
        chk("timeout_sb_drained", sb.size(), 0);
        repeat (4) @(negedge clk);
        chk("timeout_mem_req_low", {mem_req, busy}, 0);
        waits = 0; hang_from = -1;

        start();
        repeat (16) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_done_next", {load_done, busy, aborted}, 3'b101);
        chk("abort_accepted", records_accepted, 0);
        @(posedge clk); #1;
        chk("abort_idle", {load_done, busy, mem_req, aborted}, 4'b0001);

        start();
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_mem_req", mem_req, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midscan_reset");
        @(posedge clk); #1 rst = 1'b0;
        run_scan("restart", 16, 0, 30);

        put_rec(16'hFFF8, 0, 8'hA5, req_id, req_ver, 0);
        put_rec(16'hFFF8, 1, 8'hA5, req_id, req_ver, 0);
        pulse_clr();
        @(posedge clk); #1 load_start2 = 1'b1;
        @(posedge clk); #1 load_start2 = 1'b0;
        rel = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (load_done2) begin rel = k; break; end
        end
        chk("wrap_done_seen", rel >= 0, 1);
        chk("wrap_rec1_addr", addr8, 16'h0000);
        chk("wrap_counts", {records_accepted2, records_skipped2}, {8'd2, 8'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/approval_preloader.md
# approval_preloader

Reads offline-governance approval records from FRAM and streams the matching ones into the governance threshold checker's preload port, one record per `preload_valid` pulse. Sits between the FRAM read port and the `governance` block. It filters records by bitstream ID and target version, verifies a per-record XOR checksum, and reports accept, skip and error counts. Signer range, duplicate and expiry checks are left to `governance`.

## Interface
- `N_RECORDS`, 16: record slots scanned (1..255).
- `BASE_ADDR`, 16'h0100: FRAM word address of record 0.
- `WORD_TIMEOUT`, 1024: maximum cycles `mem_req` may wait for `mem_rvalid`.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `load_start` in 1: pulse; starts a scan. Ignored while `busy`.
- `abort` in 1: stops the scan from any non-idle state.
- `req_bitstream_id` in 6: a record must match this ID.
- `req_target_version` in 32: a record must match this version.
- `mem_req` out 1: read request. Held with `mem_addr` stable until accepted.
- `mem_addr` out 16: FRAM word address.
- `mem_rvalid` in 1: read data valid. May assert in the same cycle as `mem_req`.
- `mem_rdata` in 32: read word.
- `preload_valid` out 1: single-cycle strobe per accepted record.
- `preload_signer_id` out 8, `preload_hash` out 128, `preload_expiry` out 32: fields of the accepted record, valid with the strobe.
- `busy` out 1, `load_done` out 1 (single-cycle pulse).
- `records_accepted` out 8, `records_skipped` out 8.
- `mem_timeout` out 1, `aborted` out 1: sticky until the next `load_start`.

## Operation
- **Record layout.** Each record is 8 words at address `BASE_ADDR + 8*i + w`, computed modulo 2^16.
  - w0 is the header: [31:24] magic, [23:16] signer_id, [13:8] bitstream_id.
  - w1 is target_version.
  - w2 is expiry.
  - w3..w6 are the hash, with w3 in bits [127:96] and w6 in bits [31:0].
  - w7 is the checksum, equal to w0^w1^...^w6.
- **States.** IDLE, REQ, GAP, CHECK, EMIT, DONE.
- **IDLE.**
  - On `load_start`: clear the counters and sticky flags, set `busy=1`, set record index 0, go to REQ.
- **REQ.**
  - `mem_req=1`.
  - On `mem_rvalid`: capture the word, drop `mem_req`, go to GAP.
  - The per-word timeout counter increments each REQ cycle. When it reaches `WORD_TIMEOUT`: set `mem_timeout=1`, go to DONE.
- **Header rules (applied on w0 capture).**
  - magic 8'hFF marks the end of the table: go to DONE. The record is not counted.
  - If magic ≠ 8'hA5, or the bitstream_id field ≠ `req_bitstream_id`: increment `records_skipped` and advance to the next record without reading w1..w7.
- **Word sequencing.** GAP lasts one cycle with `mem_req=0`. It then returns to REQ for the next word, or goes to CHECK after w7.
- **CHECK (one cycle).**
  - Accept the record if w1 == `req_target_version` and the checksum matches. Go to EMIT.
  - Otherwise increment `records_skipped` and go to the next record.
- **EMIT (one cycle).** `preload_valid=1` with the fields driven, increment `records_accepted`, go to the next record.
- **Next record.** Increment the index. If the index equals `N_RECORDS`, go to DONE; otherwise go to REQ.
- **DONE (one cycle).** `load_done=1`, `busy=0`, then IDLE. Counters and flags hold until the next `load_start`.
- **Abort.** `abort` in REQ, GAP, CHECK or EMIT:
  - Next cycle: DONE, `aborted=1`, `mem_req=0`.
  - No `preload_valid` is issued, including for a record in CHECK.
- **Precedence.** `abort` wins over `mem_rvalid`, timeout and EMIT in the same cycle.
- **Widths.** Counters are 8 bits and cannot overflow because `N_RECORDS` ≤ 255.

## Timing
- **Reset values.** Every output is 0, including `mem_addr`, `preload_hash` and the counters. State is IDLE.
- **Reset mid-scan.** Immediate return to reset values. `mem_req` drops asynchronously.
- **Zero-wait memory, `load_start` at cycle 0:**
  - `mem_req` is high in odd cycles 1..15 (record 0).
  - CHECK is cycle 16; `preload_valid` is cycle 17.
  - Record 1 `mem_req` is cycle 18.
- **Per-record cost.**
  - Accepted record: 17 cycles.
  - Checksum or version reject: 16 cycles.
  - Header reject: 2 cycles.
  - `load_done` falls one cycle after the last record's final state.
- **Wait states.** Each wait cycle of `mem_rvalid` adds one cycle to that word.
- **Handshake.** A word is consumed only in a cycle where both `mem_req` and `mem_rvalid` are high. `mem_rvalid` while `mem_req=0` is ignored.

## Test plan
- **Full table.** 16 valid, matching records; zero-wait memory.
  - Expect 16 `preload_valid` pulses at cycles 17+17k.
  - Expect `load_done` at cycle 273, `records_accepted`=16, `records_skipped`=0.
- **Mixed table.** Record 2 has magic 8'h00, record 3 has a wrong version, record 4 has checksum word ^1, record 5 has magic 8'hFF.
  - Expect 2 accepted, 3 skipped, `load_done`, and no reads beyond address `BASE_ADDR`+40.
- **Wait states and timeout.** Memory adds 3 wait cycles per word, and every read from w5 of record 1 onward never returns.
  - Expect `mem_timeout`=1 after 1024 REQ cycles, `records_accepted`=1, and `mem_req` low afterwards.
- **Abort during EMIT.** Assert `abort` in the record-0 EMIT cycle.
  - Expect no `preload_valid`, `aborted`=1, and `load_done` the next cycle.
- **Reset mid-scan and restart.** Assert `rst` at cycle 9.
  - Expect all outputs 0 immediately.
  - Expect a fresh `load_start` to reproduce the first scenario's timing.
- **Start while busy, and wrap.** Pulse `load_start` while `busy`: expect it ignored. With `BASE_ADDR`=16'hFFF8, expect record 1 at address 16'h0000.
